// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: decode-side inputs, write-back snoop port,
// and the registered EX-stage copies plus hazard/bubble status.
// slave = the ID/EX stage itself, master = whatever drives decode and consumes EX.
interface id_ex_stage_if;
  // decode-slot inputs
  logic        ValidIn;
  logic        Stall;
  logic        Flush;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  Rd;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic [63:0] Imm;
  logic [7:0]  CtrlIn;
  // write-back port as seen by the register file
  logic [4:0]  WBWriteReg;
  logic [63:0] WBWriteData;
  logic        WBRegWrite;
  // EX-stage registered copies
  logic        ValidOut;
  logic [63:0] ReadData1Out;
  logic [63:0] ReadData2Out;
  logic [63:0] ImmOut;
  logic [4:0]  ReadReg1Out;
  logic [4:0]  ReadReg2Out;
  logic [4:0]  RdOut;
  logic [7:0]  CtrlOut;
  // status
  logic        HazardStall;
  logic [15:0] BubbleCount;

  modport master (
    output ValidIn, Stall, Flush, ReadReg1, ReadReg2, Rd,
           ReadData1, ReadData2, Imm, CtrlIn,
           WBWriteReg, WBWriteData, WBRegWrite,
    input  ValidOut, ReadData1Out, ReadData2Out, ImmOut,
           ReadReg1Out, ReadReg2Out, RdOut, CtrlOut,
           HazardStall, BubbleCount
  );

  modport slave (
    input  ValidIn, Stall, Flush, ReadReg1, ReadReg2, Rd,
           ReadData1, ReadData2, Imm, CtrlIn,
           WBWriteReg, WBWriteData, WBRegWrite,
    output ValidOut, ReadData1Out, ReadData2Out, ImmOut,
           ReadReg1Out, ReadReg2Out, RdOut, CtrlOut,
           HazardStall, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Priority on each rising clk: Flush > Stall > load-use bubble > normal load.
// Optional feature: define WB_BYPASS_EN to forward the write-back value into
// the captured operands when WB writes a register being read this cycle
// (register 31 is the zero register and is never forwarded or hazarded).
module id_ex_stage (
  input logic         clk,
  input logic         Reset,
  id_ex_stage_if.slave bus
);
  localparam logic [4:0] XZR = 5'd31;

  logic        hazard;
  logic        bubbleEvent;
  logic [4:0]  srcReg  [2];
  logic [63:0] srcData [2];
  logic [63:0] capData [2];

  logic        validNext;
  logic [7:0]  ctrlNext;
  logic [4:0]  rdNext;
  logic [4:0]  readReg1Next;
  logic [4:0]  readReg2Next;
  logic [63:0] readData1Next;
  logic [63:0] readData2Next;
  logic [63:0] immNext;
  logic [15:0] bubbleCountNext;

  assign srcReg[0]  = bus.ReadReg1;
  assign srcReg[1]  = bus.ReadReg2;
  assign srcData[0] = bus.ReadData1;
  assign srcData[1] = bus.ReadData2;

  // Operand capture path, optionally forwarding the in-flight write-back value
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
`ifdef WB_BYPASS_EN
      assign capData[gi] = (bus.WBRegWrite && (bus.WBWriteReg == srcReg[gi]) &&
                            (bus.WBWriteReg != XZR)) ? bus.WBWriteData : srcData[gi];
`else
      assign capData[gi] = srcData[gi];
`endif
    end
  endgenerate

`ifndef WB_BYPASS_EN
  // Write-back snoop port is deliberately ignored in this build
  logic wbUnused;
  assign wbUnused = bus.WBRegWrite ^ (^bus.WBWriteReg) ^ (^bus.WBWriteData) ^
                    (^srcReg[0]) ^ (^srcReg[1]);
`endif

  // Load-use hazard: EX holds a valid load whose destination a decode source needs
  always_comb begin
    hazard = bus.ValidIn && bus.ValidOut && bus.CtrlOut[1] && (bus.RdOut != XZR) &&
             ((bus.RdOut == bus.ReadReg1) || (bus.RdOut == bus.ReadReg2));
  end

  assign bus.HazardStall = hazard;

  // A real instruction is dropped when flushed, or when a bubble replaces it
  assign bubbleEvent = bus.ValidIn && (bus.Flush || (!bus.Stall && hazard));

  // Next-state selection for the pipeline register and bubble counter
  always_comb begin
    validNext       = bus.ValidOut;
    ctrlNext        = bus.CtrlOut;
    rdNext          = bus.RdOut;
    readReg1Next    = bus.ReadReg1Out;
    readReg2Next    = bus.ReadReg2Out;
    readData1Next   = bus.ReadData1Out;
    readData2Next   = bus.ReadData2Out;
    immNext         = bus.ImmOut;
    bubbleCountNext = bus.BubbleCount;

    if (bus.Flush || (!bus.Stall && hazard)) begin
      validNext     = 1'b0;
      ctrlNext      = '0;
      rdNext        = '0;
      readReg1Next  = '0;
      readReg2Next  = '0;
      readData1Next = '0;
      readData2Next = '0;
      immNext       = '0;
    end else if (!bus.Stall) begin
      validNext     = bus.ValidIn;
      ctrlNext      = bus.ValidIn ? bus.CtrlIn : 8'h00;
      rdNext        = bus.Rd;
      readReg1Next  = bus.ReadReg1;
      readReg2Next  = bus.ReadReg2;
      readData1Next = capData[0];
      readData2Next = capData[1];
      immNext       = bus.Imm;
    end

    // Saturating: once at all-ones the counter stays there
    if (bubbleEvent && (bus.BubbleCount != 16'hFFFF)) begin
      bubbleCountNext = bus.BubbleCount + 16'd1;
    end
  end

  // Pipeline register; reset clears everything immediately, independent of clk
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      bus.ValidOut     <= 1'b0;
      bus.CtrlOut      <= '0;
      bus.RdOut        <= '0;
      bus.ReadReg1Out  <= '0;
      bus.ReadReg2Out  <= '0;
      bus.ReadData1Out <= '0;
      bus.ReadData2Out <= '0;
      bus.ImmOut       <= '0;
      bus.BubbleCount  <= '0;
    end else begin
      bus.ValidOut     <= validNext;
      bus.CtrlOut      <= ctrlNext;
      bus.RdOut        <= rdNext;
      bus.ReadReg1Out  <= readReg1Next;
      bus.ReadReg2Out  <= readReg2Next;
      bus.ReadData1Out <= readData1Next;
      bus.ReadData2Out <= readData2Next;
      bus.ImmOut       <= immNext;
      bus.BubbleCount  <= bubbleCountNext;
    end
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port ValidIn, input, 1, decode slot holds a real instruction.
REQ-004 SHALL have ports Stall and Flush, input, 1 each, hold / kill request from pipeline control.
REQ-005 SHALL have ports ReadReg1, ReadReg2, Rd, input, 5 each, source and destination register numbers.
REQ-006 SHALL have ports ReadData1, ReadData2, input, 64 each, register-file read data.
REQ-007 SHALL have port Imm, input, 64, sign-extended immediate.
REQ-008 SHALL have port CtrlIn, input, 8; bit0 RegWrite, bit1 MemRead, bit2 MemWrite, bit3 MemtoReg, bit4 ALUSrc, bit5 Branch, bits7:6 ALUOp.
REQ-009 SHALL have ports WBWriteReg (5), WBWriteData (64), WBRegWrite (1), input, write-back port as driven into the register file.
REQ-010 SHALL have outputs ValidOut (1), ReadData1Out, ReadData2Out, ImmOut (64 each), ReadReg1Out, ReadReg2Out, RdOut (5 each), CtrlOut (8), registered EX-stage copies.
REQ-011 SHALL have output HazardStall, 1, combinational load-use stall request to PC and IF/ID.
REQ-012 SHALL have output BubbleCount, 16, registered count of inserted bubbles.

Function
REQ-013 SHALL update all registered outputs only on rising clk, per priority Flush > Stall > HazardStall > load.
REQ-014 SHALL on Flush=1 clear ValidOut and CtrlOut to 0; data/register fields don't-care but SHALL be cleared to 0.
REQ-015 SHALL on Stall=1 (Flush=0) hold every registered output, including BubbleCount.
REQ-016 SHALL assert HazardStall = ValidIn & ValidOut & CtrlOut[1] & (RdOut!=31) & (RdOut==ReadReg1 | RdOut==ReadReg2), independent of Stall/Flush.
REQ-017 SHALL on HazardStall=1 (Flush=0, Stall=0) insert a bubble: ValidOut=0, CtrlOut=0, other fields cleared.
REQ-018 SHALL otherwise load all inputs: ValidOut<=ValidIn, CtrlOut<=ValidIn?CtrlIn:0, fields from corresponding inputs.
REQ-019 SHALL increment BubbleCount by 1 on any edge where a bubble is inserted by Flush or HazardStall with ValidIn=1, saturating at 0xFFFF (no wrap).
REQ-020 SHALL give latency of exactly one cycle from input to registered output.
REQ-021 SHALL treat register 31 (XZR) as never hazarding and never bypassed.

Reset
REQ-022 SHALL on Reset=0 immediately force all registered outputs, including BubbleCount, to 0, regardless of clk.
REQ-023 SHALL resume normal loading on the first rising clk after Reset returns to 1; a mid-stream reset discards the held instruction.

Configuration
REQ-024 SHALL with macro WB_BYPASS_EN defined substitute WBWriteData for ReadData1 (resp. ReadData2) at capture when WBRegWrite=1, WBWriteReg==ReadReg1 (resp. ReadReg2), WBWriteReg!=31.
REQ-025 SHALL without WB_BYPASS_EN capture ReadData1/ReadData2 unmodified, WB inputs unused.

Verification
REQ-026 Reset=0 mid-run with ValidOut=1, BubbleCount=5 -> all outputs 0 before next clk edge.
REQ-027 ValidIn=1, Rd=3, CtrlIn=0x01, ReadData1=0x10, Imm=4 -> next cycle ValidOut=1, RdOut=3, ReadData1Out=0x10, ImmOut=4.
REQ-028 EX holds load (CtrlOut=0x0A, RdOut=5), ID ReadReg2=5 -> HazardStall=1; next edge ValidOut=0, BubbleCount+1; RdOut=31 case -> HazardStall=0.
REQ-029 Stall=1 and Flush=1 same edge -> bubble (ValidOut=0); Stall=1 alone with HazardStall=1 -> outputs held, BubbleCount unchanged.
REQ-030 WB_BYPASS_EN defined, WBRegWrite=1, WBWriteReg=3, WBWriteData=4, ReadReg1=3, ReadData1=0 -> ReadData1Out=4; undefined -> 0.
REQ-031 BubbleCount preloaded to 0xFFFE via repeated flushes -> two more flushes yield 0xFFFF, 0xFFFF.
